// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions.
//   BP_CTR_INIT(w) : reset value of a w-bit saturating counter (weakly not-taken).
//   bp_hash        : pattern-table index hash (pc index bits XOR zero-extended history).
//                    Callers truncate the 32-bit result to their index width, so
//                    IF-side debug and checkers compute exactly the same index.
package bp_pkg;

  function automatic int BP_CTR_INIT(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic logic [31:0] bp_hash(input logic [31:0] pc_bits,
                                          input logic [31:0] ghr);
    return pc_bits ^ ghr;
  endfunction

endpackage

// File: rtl/sat_counter_update.sv
// Combinational next value of a COUNTER_WIDTH-bit saturating counter.
// Ports:
//   ctr_in  : current counter value
//   taken   : 1 = count up, 0 = count down
//   ctr_out : next value, clamped to [0, 2^COUNTER_WIDTH-1] (never wraps)
module sat_counter_update #(
  parameter int COUNTER_WIDTH = 2
) (
  input  logic [COUNTER_WIDTH-1:0] ctr_in,
  input  logic                     taken,
  output logic [COUNTER_WIDTH-1:0] ctr_out
);

  always_comb begin
    ctr_out = ctr_in;
    if (taken) begin
      if (ctr_in != {COUNTER_WIDTH{1'b1}}) ctr_out = ctr_in + 1'b1;
    end else begin
      if (ctr_in != '0) ctr_out = ctr_in - 1'b1;
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// gshare direction predictor for the IF stage.
// A table of saturating counters is indexed by pc[PREDICTOR_WIDTH+1:2] XOR
// the speculative global history register (GHR). The GHR shifts in each
// predicted direction and is repaired from the branch's snapshot on mispredict.
//
// Configuration macro: BP_GSHARE_EN
//   defined   : gshare hashing with GHR (shift / repair).
//   undefined : bimodal; index = pc bits only, no GHR, pred_ghr = 0,
//               update_ghr and update_mispredict ignored.
//
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (low freezes all state)
//   now_pc, predict_valid   -> jump, pred_ghr   (combinational, zero latency)
//   update_control, update_jump, update_pc, update_ghr, update_mispredict
//
// There is no handshake: predict_valid and update_control are single-cycle
// strobes that are always accepted in the cycle they are high (when rdy_in).
module gshare_predictor
  import bp_pkg::*;
#(
  parameter int PREDICTOR_WIDTH = 6,
  parameter int HISTORY_WIDTH   = 4,
  parameter int COUNTER_WIDTH   = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic [31:0]              now_pc,
  input  logic                     predict_valid,
  output logic                     jump,
  output logic [HISTORY_WIDTH-1:0] pred_ghr,
  input  logic                     update_control,
  input  logic                     update_jump,
  input  logic [31:0]              update_pc,
  input  logic [HISTORY_WIDTH-1:0] update_ghr,
  input  logic                     update_mispredict
);

  localparam int DEPTH = 1 << PREDICTOR_WIDTH;
  localparam logic [COUNTER_WIDTH-1:0] CTR_INIT = COUNTER_WIDTH'(BP_CTR_INIT(COUNTER_WIDTH));

  logic [COUNTER_WIDTH-1:0]   table_q [DEPTH];
  logic [PREDICTOR_WIDTH-1:0] pred_idx;
  logic [PREDICTOR_WIDTH-1:0] upd_idx;
  logic [COUNTER_WIDTH-1:0]   upd_ctr_next;
  logic [HISTORY_WIDTH-1:0]   hist_for_pred;
  logic [HISTORY_WIDTH-1:0]   hist_for_upd;

`ifdef BP_GSHARE_EN
  logic [HISTORY_WIDTH-1:0] ghr_q;
  logic [HISTORY_WIDTH-1:0] ghr_d;

  assign hist_for_pred = ghr_q;
  assign hist_for_upd  = update_ghr;

  // Truncating {hist, bit} to HISTORY_WIDTH drops the oldest bit; this also
  // covers HISTORY_WIDTH == 1 (result is just the new bit).
  // Repair wins over a same-cycle shift: that prediction is being flushed.
  always_comb begin
    ghr_d = ghr_q;
    if (update_control && update_mispredict)
      ghr_d = HISTORY_WIDTH'({update_ghr, update_jump});
    else if (predict_valid)
      ghr_d = HISTORY_WIDTH'({ghr_q, jump});
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)      ghr_q <= '0;
    else if (rdy_in) ghr_q <= ghr_d;
  end

  assign pred_ghr = ghr_q;

  logic unused_inputs;
  assign unused_inputs = ^{now_pc[31:PREDICTOR_WIDTH+2], now_pc[1:0],
                           update_pc[31:PREDICTOR_WIDTH+2], update_pc[1:0]};
`else
  assign hist_for_pred = '0;
  assign hist_for_upd  = '0;
  assign pred_ghr      = '0;

  logic unused_inputs;
  assign unused_inputs = ^{now_pc[31:PREDICTOR_WIDTH+2], now_pc[1:0],
                           update_pc[31:PREDICTOR_WIDTH+2], update_pc[1:0],
                           update_ghr, update_mispredict, predict_valid};
`endif

  assign pred_idx = PREDICTOR_WIDTH'(bp_hash(32'(now_pc[PREDICTOR_WIDTH+1:2]),
                                             32'(hist_for_pred)));
  assign upd_idx  = PREDICTOR_WIDTH'(bp_hash(32'(update_pc[PREDICTOR_WIDTH+1:2]),
                                             32'(hist_for_upd)));

  // Reads the registered table, so a same-cycle update to pred_idx is not
  // bypassed: the prediction sees the pre-update counter.
  assign jump = table_q[pred_idx][COUNTER_WIDTH-1];

  sat_counter_update #(
    .COUNTER_WIDTH(COUNTER_WIDTH)
  ) u_ctr_upd (
    .ctr_in (table_q[upd_idx]),
    .taken  (update_jump),
    .ctr_out(upd_ctr_next)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) table_q[i] <= CTR_INIT;
    end else if (rdy_in && update_control) begin
      table_q[upd_idx] <= upd_ctr_next;
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
module tb_gshare_predictor;

  localparam int PW = 6;
  localparam int HW = 4;
  localparam int CW = 2;
`ifdef BP_GSHARE_EN
  localparam bit GS = 1'b1;
  localparam logic [31:0] COL_PC = 32'h0000_000C;  // idx 3 ^ ghr 6 = 5
`else
  localparam bit GS = 1'b0;
  localparam logic [31:0] COL_PC = 32'h0000_0014;  // idx 5
`endif

  // clock / reset
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic          rdy_in = 1'b1;
  logic [31:0]   now_pc = '0;
  logic          predict_valid = 1'b0;
  logic          jump;
  logic [HW-1:0] pred_ghr;
  logic          update_control = 1'b0;
  logic          update_jump = 1'b0;
  logic [31:0]   update_pc = '0;
  logic [HW-1:0] update_ghr = '0;
  logic          update_mispredict = 1'b0;

  int checks = 0;
  int errors = 0;

  gshare_predictor #(
    .PREDICTOR_WIDTH(PW),
    .HISTORY_WIDTH  (HW),
    .COUNTER_WIDTH  (CW)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .now_pc           (now_pc),
    .predict_valid    (predict_valid),
    .jump             (jump),
    .pred_ghr         (pred_ghr),
    .update_control   (update_control),
    .update_jump      (update_jump),
    .update_pc        (update_pc),
    .update_ghr       (update_ghr),
    .update_mispredict(update_mispredict)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_ctl();
    predict_valid     = 1'b0;
    update_control    = 1'b0;
    update_jump       = 1'b0;
    update_mispredict = 1'b0;
    update_ghr        = '0;
    update_pc         = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic train_taken(input logic [31:0] pc);
    update_control = 1'b1;
    update_jump    = 1'b1;
    update_pc      = pc;
    update_ghr     = '0;
    tick();
    clear_ctl();
  endtask

  logic [HW-1:0] ghr_seq [5];

  initial begin
    ghr_seq = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hF};

    // Reset asserted between edges; values must appear without a clock edge.
    #3 rst_in = 1'b1;
    #1;
    chk("rst_jump_async", 32'(jump), 32'd0);
    chk("rst_ghr_async", 32'(pred_ghr), 32'd0);
    rst_in = 1'b0;
    for (int i = 0; i < (1 << PW); i++) begin
      now_pc = 32'(i) << 2;
      #0.2;
      chk("rst_sweep_jump", 32'(jump), 32'd0);
      chk("rst_sweep_ghr", 32'(pred_ghr), 32'd0);
    end
    tick();

    // Saturation at pc 0x10 (idx 4): 1->2->3->3->3, then 2, then 1.
    now_pc = 32'h10;
    for (int k = 0; k < 4; k++) begin
      update_control = 1'b1; update_jump = 1'b1; update_pc = 32'h10; update_ghr = '0;
      tick();
      chk("sat_up_jump", 32'(jump), 32'd1);
    end
    update_jump = 1'b0;
    tick();
    chk("sat_dn1_jump", 32'(jump), 32'd1);
    tick();
    chk("sat_dn2_jump", 32'(jump), 32'd0);
    clear_ctl();
    settle();
    chk("sat_ghr_idle", 32'(pred_ghr), 32'd0);

    // Train indices walked by the history-shift sequence, plus idx 0xB.
    train_taken(32'h20 << 2);
    train_taken(32'h21 << 2);
    train_taken(32'h23 << 2);
    train_taken(32'h27 << 2);
    train_taken(32'h2F << 2);
    train_taken(32'h0B << 2);

    // History shift: five taken predictions at pc 0x80.
    now_pc = 32'h80;
    predict_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("hist_jump", 32'(jump), 32'd1);
      tick();
      chk("hist_ghr", 32'(pred_ghr), GS ? 32'(ghr_seq[k]) : 32'd0);
    end
    predict_valid = 1'b0;
    now_pc = 32'h10;  // gshare: idx 4^F = 0xB (trained), bimodal: idx 4 (ctr 1)
    settle();
    chk("hist_hash_idx", 32'(jump), GS ? 32'd1 : 32'd0);

    // Repair: force ghr = 1010 via mispredict with snapshot 0101, jump 0.
    update_control = 1'b1; update_mispredict = 1'b1; update_jump = 1'b0;
    update_ghr = 4'b0101; update_pc = 32'hC0;
    tick();
    chk("repair_set", 32'(pred_ghr), GS ? 32'hA : 32'd0);
    // Repair and predict in the same cycle: repair wins.
    predict_valid = 1'b1;
    update_ghr = 4'b0011;
    tick();
    chk("repair_prio", 32'(pred_ghr), GS ? 32'h6 : 32'd0);
    clear_ctl();

    // Same-index collision at idx 5 (counter 1): update taken while reading it.
    now_pc = COL_PC;
    update_control = 1'b1; update_jump = 1'b1; update_pc = COL_PC; update_ghr = 4'h6;
    settle();
    chk("collide_pre", 32'(jump), 32'd0);
    tick();
    clear_ctl();
    settle();
    chk("collide_post", 32'(jump), 32'd1);

    // rdy_in low: everything that could change state is active, nothing may.
    rdy_in = 1'b0;
    predict_valid = 1'b1;
    update_control = 1'b1; update_jump = 1'b0; update_pc = COL_PC; update_ghr = 4'h6;
    update_mispredict = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("frz_jump", 32'(jump), 32'd1);
      chk("frz_ghr", 32'(pred_ghr), GS ? 32'h6 : 32'd0);
    end
    rdy_in = 1'b1;
    clear_ctl();
    tick();
    chk("frz_after_jump", 32'(jump), 32'd1);

    // Mispredict without update_control is ignored.
    update_mispredict = 1'b1; update_ghr = 4'hF; update_jump = 1'b1;
    tick();
    chk("mispred_noctl_ghr", 32'(pred_ghr), GS ? 32'h6 : 32'd0);
    chk("mispred_noctl_jump", 32'(jump), 32'd1);
    clear_ctl();

    // Reset mid-operation between edges.
    #2 rst_in = 1'b1;
    #1;
    chk("midrst_jump", 32'(jump), 32'd0);
    chk("midrst_ghr", 32'(pred_ghr), 32'd0);
    rst_in = 1'b0;
    now_pc = 32'h80;
    settle();
    chk("midrst_idx20", 32'(jump), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gshare_predictor.md
# gshare_predictor

Parametrised direction predictor for the IF stage: a pattern table of saturating counters indexed by PC XOR global history (gshare). A speculative global history register (GHR) is shifted on each predicted branch and repaired on mispredict. Replaces the per-entry local-history predictor. Its IF-side interface is a superset of that predictor's, with added snapshot and repair ports toward ROB/commit.

## Interface
- PREDICTOR_WIDTH, 6: log2 of pattern-table entries; index is `pc[PREDICTOR_WIDTH+1:2]`.
- HISTORY_WIDTH, 4: GHR bits, 1 ≤ HISTORY_WIDTH ≤ PREDICTOR_WIDTH.
- COUNTER_WIDTH, 2: saturating counter bits, ≥ 1.

Ports:
- clk_in  input  1  clock; all state updates on posedge.
- rst_in  input  1  reset, asynchronous, active-high.
- rdy_in  input  1  global ready; low freezes all state.
- now_pc  input  32  PC of the instruction being fetched.
- predict_valid  input  1  IF has a conditional branch at now_pc and consumes `jump` this cycle.
- jump  output  1  predicted direction for now_pc.
- pred_ghr  output  HISTORY_WIDTH  GHR value used for this prediction; IF carries it with the branch.
- update_control  input  1  a conditional branch resolves this cycle.
- update_jump  input  1  resolved direction.
- update_pc  input  32  PC of the resolved branch.
- update_ghr  input  HISTORY_WIDTH  pred_ghr snapshot carried with the resolved branch.
- update_mispredict  input  1  resolved direction ≠ predicted; qualified by update_control.

## Operation
- Predict index: `now_pc[PREDICTOR_WIDTH+1:2] XOR {0, ghr}`; GHR is zero-extended on the MSB side.
- Update index: `update_pc[PREDICTOR_WIDTH+1:2] XOR {0, update_ghr}`.
- jump = MSB of the indexed counter. pred_ghr = current GHR.
- Counter update on update_control: saturating +1 if update_jump, otherwise saturating −1.
  - Saturation bounds are 0 and 2^COUNTER_WIDTH−1; no wrap.
- GHR shift on predict_valid: ghr ← {ghr[HISTORY_WIDTH-2:0], jump}. With HISTORY_WIDTH=1, ghr ← jump.
- GHR repair on update_control & update_mispredict: ghr ← {update_ghr[HISTORY_WIDTH-2:0], update_jump}.
- Repair has priority over a same-cycle predict_valid shift; that shift is dropped because IF is being flushed.
- Same-cycle update and predict to the same index: the prediction uses the pre-update counter. There is no bypass.
- rdy_in low: no counter or GHR change. jump and pred_ghr remain valid combinationally.
- update_mispredict without update_control is ignored.

## Timing
- Reset (asynchronous, immediate):
  - every counter = 2^(COUNTER_WIDTH−1)−1 (weakly not-taken; 1 for W=2);
  - ghr = 0;
  - hence jump = 0 and pred_ghr = 0.
- When rst_in deasserts, state holds reset values until the first qualified posedge.
- Prediction latency: zero cycles; jump and pred_ghr are combinational from now_pc and ghr.
- Update latency: the counter write and GHR shift/repair are visible on jump and pred_ghr after the next posedge.
- Reset mid-operation overrides all in-flight updates. Outstanding snapshots are meaningless afterwards, and the pipeline is flushed by the same reset.
- No handshake or backpressure: every update is accepted in its cycle.

## Configuration
- BP_GSHARE_EN defined: XOR hashing and GHR behaviour as above.
- BP_GSHARE_EN undefined (bimodal mode):
  - index = PC bits only;
  - GHR register is not built; pred_ghr is tied to 0;
  - update_ghr and update_mispredict are ignored;
  - counter behaviour is unchanged.

## Structure
- Shared package `bp_pkg`:
  - counter reset constant `BP_CTR_INIT(W)`;
  - index-hash function (pc bits, ghr → index), so IF-side debug and checkers use the same hash.
- One sub-module `sat_counter_update`: combinational next-value of a COUNTER_WIDTH saturating counter given taken/not-taken.
- The top level owns the table array, the GHR and the priority logic.

## Test plan
- Reset: pulse rst_in asynchronously between edges, then sweep now_pc over all 64 indices → jump=0, pred_ghr=0 for every index, with no clock edge needed.
- Saturation: 4 taken updates to pc=0x10 with update_ghr=0 → counter 1→2→3→3; jump=1 after the 1st update. Then 1 not-taken → counter 2, jump=1. A 2nd not-taken → counter 1, jump=0.
- History shift: 5 consecutive predict_valid with jump=1 and HISTORY_WIDTH=4 → pred_ghr goes 0→1→3→7→F→F.
  - Then predict pc=0x10 reads index 0x4^0xF=0xB.
- Repair priority: ghr=0b1010; same cycle predict_valid=1 plus update_control=1, update_mispredict=1, update_ghr=0b0011, update_jump=0 → next ghr=0b0110, not 0b0100 or 0b0101.
- Same-index collision: counter=1 at index 5; update taken and predict the same index in one cycle → jump=0 that cycle, jump=1 the next.
- rdy_in low for 3 cycles with update_control and predict_valid active → counters and ghr unchanged; compile without BP_GSHARE_EN → pred_ghr stuck at 0 and index = pc bits.
